// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing defaults, total derivation and coordinate type.
package vga_pkg;
  typedef logic [9:0] coord_t;
  function automatic int span_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF = 33;
  localparam int H_TOTAL_DEF = span_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = span_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);
endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: enable-gated shift register; depth 0 is a wire forced to RST_VAL in reset.
module sync_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  if (DEPTH == 0) begin : g_wire
    assign dout = rst_n ? din : RST_VAL;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else if (en) begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    assign dout = stage[DEPTH-1];
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: h/v raster counters with registered decodes and delayed sync/blank outputs.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP = V_BP_DEF,
  parameter int PIPE_DLY = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_active,
  output logic       o_line_start,
  output logic       o_frame_start,
  output logic       o_VGA_HS,
  output logic       o_VGA_VS,
  output logic       o_VGA_BLANK_N,
  output logic       o_VGA_SYNC_N
);
  localparam coord_t H_LAST = coord_t'(span_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam coord_t V_LAST = coord_t'(span_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam coord_t H_ACT = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT = coord_t'(V_ACTIVE);
  localparam coord_t HS_BEG = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_BEG = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END = coord_t'(V_ACTIVE + V_FP + V_SYNC);
  coord_t h, v, h_nxt, v_nxt;
  logic active, line_start, frame_start, hs_raw, vs_raw;
  always_comb begin
    h_nxt = (h == H_LAST) ? '0 : h + coord_t'(1);
    v_nxt = (h != H_LAST) ? v : (v == V_LAST) ? '0 : v + coord_t'(1);
  end
  // Decodes are computed from the next counts so they line up with o_x/o_y.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      h <= '0;
      v <= '0;
      active <= 1'b1;
      line_start <= 1'b1;
      frame_start <= 1'b1;
    end else if (i_en) begin
      h <= h_nxt;
      v <= v_nxt;
      active <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
      line_start <= h_nxt == '0;
      frame_start <= (h_nxt == '0) && (v_nxt == '0);
    end
  assign hs_raw = !((h >= HS_BEG) && (h < HS_END));
  assign vs_raw = !((v >= VS_BEG) && (v < VS_END));
  sync_delay_line #(.WIDTH(3), .DEPTH(PIPE_DLY), .RST_VAL(3'b110)) u_dly (
    .clk(i_clk),
    .rst_n(i_rst_n),
    .en(i_en),
    .din({hs_raw, vs_raw, active}),
    .dout({o_VGA_HS, o_VGA_VS, o_VGA_BLANK_N})
  );
  assign o_x = h;
  assign o_y = v;
  assign o_active = active;
  assign o_line_start = line_start;
  assign o_frame_start = frame_start;
  assign o_VGA_SYNC_N = 1'b0;
endmodule
